bist_response_analyzer: RTL

- Downstream BIST stage for the 4x4 Booth multiplier.
- Consumes the multiplier's `product` and `busy` outputs during a self-test session.
- Compresses NUM_PATTERNS results into an 8-bit MISR signature, then compares it against a golden signature.
- Drives `pass`/`done` to the test controller and bench, replacing the ad-hoc product check.

---
 rtl/bist_response_analyzer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts multiplier products into a Galois MISR and
// compares the final signature with GOLDEN_SIG. Optional watchdog: BIST_TIMEOUT_EN.
module bist_response_analyzer #(
  parameter int unsigned         WIDTH          = 8,
  parameter int unsigned         NUM_PATTERNS   = 16,
  parameter logic [WIDTH-1:0]    SEED           = 8'hFF,
  parameter logic [WIDTH-1:0]    POLY           = 8'h1D,
  parameter logic [WIDTH-1:0]    GOLDEN_SIG     = 8'h00,
  parameter int unsigned         TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test,
  input  logic [WIDTH-1:0] product,
  input  logic             busy,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass,
  output logic             timeout
);

  localparam int unsigned CW = $clog2(NUM_PATTERNS + 1);

  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] sig_next;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             capture;

  // A falling busy edge marks a fresh product, but only while collecting.
  assign capture = (state == RUN) && busy_q && !busy;

  always_comb begin
    sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ product;
  end

  assign signature = sig;

`ifdef BIST_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd;
  logic          tmo;

  assign timeout = tmo;

  always_ff @(posedge clk) begin
    busy_q <= busy;
    if (rst) begin
      state  <= IDLE;
      sig    <= SEED;
      count  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      tmo    <= 1'b0;
      wd     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          pass <= 1'b0;
          tmo  <= 1'b0;
          if (test) begin
            sig   <= SEED;
            count <= '0;
            wd    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Abort has priority over both a capture and a watchdog expiry.
          if (!test) begin
            state <= IDLE;
          end else if (capture) begin
            sig   <= sig_next;
            count <= count + 1'b1;
            wd    <= '0;
            if (count == CW'(NUM_PATTERNS - 1)) state <= COMPARE;
          end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= 1'b0;
            tmo   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        COMPARE: begin
          pass  <= (sig == GOLDEN_SIG);
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!test) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
            tmo   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    busy_q <= busy;
    if (rst) begin
      state  <= IDLE;
      sig    <= SEED;
      count  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          pass <= 1'b0;
          if (test) begin
            sig   <= SEED;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!test) begin
            state <= IDLE;
          end else if (capture) begin
            sig   <= sig_next;
            count <= count + 1'b1;
            if (count == CW'(NUM_PATTERNS - 1)) state <= COMPARE;
          end
        end
        COMPARE: begin
          pass  <= (sig == GOLDEN_SIG);
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!test) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
